// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM bus types plus the request-legality helper used by the RAM-side controller.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Prefixed so the literals do not collide with ramstate_t in this scope.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } ram_acc_state_t;

  localparam int unsigned LAT_MAX = 15;

  function automatic logic addr_ok(input word_t a, input int unsigned depth_w);
    return (a[1:0] == 2'b00) && ((a >> (depth_w + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// CPU/RAM request bus: the CPU side drives the request, the RAM side answers with load data and state.
interface ram_if;
  import cpu_types_pkg::*;

  word_t     memaddr;
  word_t     memstore;
  logic      memREN;
  logic      memWEN;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (output memaddr, memstore, memREN, memWEN, input ramload, ramstate);
  modport slave  (input memaddr, memstore, memREN, memWEN, output ramload, ramstate);

endinterface

// File: rtl/ram_access_ctrl_stat_cnt.sv
// Wrapping 32-bit completion/abort counters for ram_access_ctrl (built only with RAM_STATS_EN).
module ram_stat_cnt
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  rd_done,
  input  logic  wr_done,
  input  logic  abort,
  output word_t stat_reads,
  output word_t stat_writes,
  output word_t stat_aborts
);

  word_t reads_r, writes_r, aborts_r;

  // Event counters; wrap at 2^32 by natural overflow.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      reads_r  <= 32'd0;
      writes_r <= 32'd0;
      aborts_r <= 32'd0;
    end else begin
      if (rd_done) reads_r  <= reads_r + 32'd1;
      if (wr_done) writes_r <= writes_r + 32'd1;
      if (abort)   aborts_r <= aborts_r + 32'd1;
    end
  end

  assign stat_reads  = reads_r;
  assign stat_writes = writes_r;
  assign stat_aborts = aborts_r;

endmodule

// File: rtl/ram_access_ctrl.sv
// RAM-side bus controller: wait-state sequencing onto a synchronous SRAM with abort/error handling.
// Optional statistics counters are built when RAM_STATS_EN is defined.
module ram_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT     = 2,
  parameter int unsigned DEPTH_W = 14
) (
  input  logic               CLK,
  input  logic               nRST,
  ram_if.slave               bus,
  output logic [DEPTH_W-1:0] sram_addr,
  output word_t              sram_wdata,
  output logic               sram_ren,
  output logic               sram_wen,
  input  word_t              sram_rdata,
  output word_t              stat_reads,
  output word_t              stat_writes,
  output word_t              stat_aborts
);

  ram_acc_state_t state_r, state_s;
  logic [3:0]     cnt_r;
  word_t          addr_r, data_r;
  logic           op_wr_r;
  logic           req_any_s, req_ok_s, match_s, load_s;
  ramstate_t      idle_rs_s;

  assign req_any_s = bus.memREN | bus.memWEN;
  assign req_ok_s  = (bus.memREN ^ bus.memWEN) && addr_ok(bus.memaddr, DEPTH_W);
  assign match_s   = (bus.memaddr == addr_r) && (bus.memWEN == op_wr_r) && (bus.memREN == !op_wr_r);
  // An abort behaves like IDLE in the same cycle, so a replacement request is latched at once.
  assign load_s    = ((state_r == ST_IDLE) || ((state_r == ST_WAIT) && !match_s)) && req_ok_s;

  // Bus state reported whenever the controller is evaluating a fresh request.
  always_comb begin
    idle_rs_s = FREE;
    if (!req_any_s) begin
      idle_rs_s = FREE;
    end else if (req_ok_s) begin
      idle_rs_s = BUSY;
    end else begin
      idle_rs_s = ERROR;
    end
  end

  // State register, wait counter and request latch.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= 32'd0;
      data_r  <= 32'd0;
      op_wr_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        cnt_r   <= 4'(LAT);
        addr_r  <= bus.memaddr;
        data_r  <= bus.memstore;
        op_wr_r <= bus.memWEN;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // Next state, bus state, load data and SRAM strobes.
  always_comb begin
    state_s      = state_r;
    bus.ramstate = FREE;
    bus.ramload  = 32'd0;
    sram_ren     = 1'b0;
    sram_wen     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        bus.ramstate = idle_rs_s;
        state_s      = req_ok_s ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (!match_s) begin
          bus.ramstate = idle_rs_s;
          state_s      = req_ok_s ? ST_WAIT : ST_IDLE;
        end else if (cnt_r == 4'd1) begin
          bus.ramstate = BUSY;
          sram_ren     = !op_wr_r;
          sram_wen     = op_wr_r;
          state_s      = ST_ACCESS;
        end else begin
          bus.ramstate = BUSY;
          state_s      = ST_WAIT;
        end
      end
      ST_ACCESS: begin
        bus.ramstate = ACCESS;
        bus.ramload  = op_wr_r ? data_r : sram_rdata;
        state_s      = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign sram_addr  = addr_r[DEPTH_W+1:2];
  assign sram_wdata = data_r;

`ifdef RAM_STATS_EN
  logic rd_done_s, wr_done_s, abort_s;

  assign rd_done_s = (state_r == ST_ACCESS) && !op_wr_r;
  assign wr_done_s = (state_r == ST_ACCESS) && op_wr_r;
  assign abort_s   = (state_r == ST_WAIT) && !match_s;

  ram_stat_cnt u_stat (
    .CLK         (CLK),
    .nRST        (nRST),
    .rd_done     (rd_done_s),
    .wr_done     (wr_done_s),
    .abort       (abort_s),
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_aborts (stat_aborts)
  );
`else
  assign stat_reads  = 32'd0;
  assign stat_writes = 32'd0;
  assign stat_aborts = 32'd0;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl (LAT=2, DEPTH_W=14) with a behavioural synchronous SRAM.
module tb_ram_access_ctrl;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [13:0] sram_addr;
  word_t       sram_wdata, sram_rdata;
  logic        sram_ren, sram_wen;
  word_t       stat_reads, stat_writes, stat_aborts;

  ram_if bus ();

  ram_access_ctrl #(.LAT(2), .DEPTH_W(14)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .bus         (bus),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_ren    (sram_ren),
    .sram_wen    (sram_wen),
    .sram_rdata  (sram_rdata),
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_aborts (stat_aborts)
  );

  always #5 CLK = ~CLK;

  // SRAM model with a bench-side preload port.
  word_t       mem [0:16383];
  logic        pre_en = 1'b0;
  logic [13:0] pre_addr = 14'd0;
  word_t       pre_data = 32'd0;
  int          ren_cnt = 0;
  int          wen_cnt = 0;

  always @(posedge CLK) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (sram_wen) mem[sram_addr] <= sram_wdata;
    if (sram_ren) sram_rdata <= mem[sram_addr];
    if (sram_ren) ren_cnt <= ren_cnt + 1;
    if (sram_wen) wen_cnt <= wen_cnt + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  int    w0, r0;
  word_t exp_r, exp_w, exp_a;

  initial begin
    bus.memaddr  = 32'd0;
    bus.memstore = 32'd0;
    bus.memREN   = 1'b0;
    bus.memWEN   = 1'b0;
    sram_rdata   = 32'd0;

    // Preload while held in reset.
    pre_en = 1'b1;
    pre_addr = 14'h10; pre_data = 32'hDEADBEEF; go();
    pre_addr = 14'h20; pre_data = 32'h12345678; go();
    pre_addr = 14'h13; pre_data = 32'hA5A5A5A5; go();
    pre_en = 1'b0;
    smp();
    chk("rst_state", 32'(bus.ramstate), 32'(FREE));
    chk("rst_load",  bus.ramload, 32'd0);
    chk("rst_ren",   32'(sram_ren), 32'd0);
    chk("rst_wen",   32'(sram_wen), 32'd0);
    go(); nRST = 1'b1;

    // Read 0x40 -> word 0x10.
    go(); bus.memREN = 1'b1; bus.memaddr = 32'h40;
    smp(); chk("rd_c0_state", 32'(bus.ramstate), 32'(BUSY)); chk("rd_c0_ren", 32'(sram_ren), 32'd0);
    go(); smp(); chk("rd_c1_state", 32'(bus.ramstate), 32'(BUSY)); chk("rd_c1_ren", 32'(sram_ren), 32'd0);
    go(); smp(); chk("rd_c2_state", 32'(bus.ramstate), 32'(BUSY)); chk("rd_c2_ren", 32'(sram_ren), 32'd1);
    chk("rd_c2_addr", 32'(sram_addr), 32'h10);
    go(); bus.memREN = 1'b0;
    smp(); chk("rd_c3_state", 32'(bus.ramstate), 32'(ACCESS)); chk("rd_c3_load", bus.ramload, 32'hDEADBEEF);
    go(); smp(); chk("rd_c4_state", 32'(bus.ramstate), 32'(FREE));

    // Write 0x44; memstore change during WAIT must be ignored.
    w0 = wen_cnt;
    go(); bus.memWEN = 1'b1; bus.memaddr = 32'h44; bus.memstore = 32'hCAFEF00D;
    smp(); chk("wr_c0_state", 32'(bus.ramstate), 32'(BUSY));
    go(); bus.memstore = 32'h11111111;
    smp(); chk("wr_c1_wen", 32'(sram_wen), 32'd0);
    go(); smp(); chk("wr_c2_wen", 32'(sram_wen), 32'd1);
    chk("wr_c2_wdata", sram_wdata, 32'hCAFEF00D); chk("wr_c2_addr", 32'(sram_addr), 32'h11);
    go(); bus.memWEN = 1'b0;
    smp(); chk("wr_c3_state", 32'(bus.ramstate), 32'(ACCESS)); chk("wr_c3_load", bus.ramload, 32'hCAFEF00D);
    go(); smp(); chk("wr_c4_state", 32'(bus.ramstate), 32'(FREE));
    chk("wr_once", 32'(wen_cnt - w0), 32'd1); chk("wr_mem", mem[14'h11], 32'hCAFEF00D);

    // Read back 0x44.
    go(); bus.memREN = 1'b1; bus.memaddr = 32'h44; bus.memstore = 32'd0;
    go(); go(); go(); bus.memREN = 1'b0;
    smp(); chk("rb_state", 32'(bus.ramstate), 32'(ACCESS)); chk("rb_load", bus.ramload, 32'hCAFEF00D);

    // Abort 0x40 by switching to 0x80 in cycle 1.
    r0 = ren_cnt;
    go(); bus.memREN = 1'b1; bus.memaddr = 32'h40;
    smp(); chk("ab_c0_state", 32'(bus.ramstate), 32'(BUSY));
    go(); bus.memaddr = 32'h80;
    smp(); chk("ab_c1_state", 32'(bus.ramstate), 32'(BUSY)); chk("ab_c1_ren", 32'(sram_ren), 32'd0);
    go(); smp(); chk("ab_c2_ren", 32'(sram_ren), 32'd0);
    go(); smp(); chk("ab_c3_ren", 32'(sram_ren), 32'd1); chk("ab_c3_addr", 32'(sram_addr), 32'h20);
    go(); bus.memREN = 1'b0;
    smp(); chk("ab_c4_state", 32'(bus.ramstate), 32'(ACCESS)); chk("ab_c4_load", bus.ramload, 32'h12345678);
    go(); smp(); chk("ab_c5_state", 32'(bus.ramstate), 32'(FREE)); chk("ab_one_ren", 32'(ren_cnt - r0), 32'd1);

    // Second write, 0x48.
    go(); bus.memWEN = 1'b1; bus.memaddr = 32'h48; bus.memstore = 32'h0BADF00D;
    go(); go(); go(); bus.memWEN = 1'b0;
    smp(); chk("wr2_state", 32'(bus.ramstate), 32'(ACCESS));
    go(); smp(); chk("wr2_mem", mem[14'h12], 32'h0BADF00D);

`ifdef RAM_STATS_EN
    exp_r = 32'd3; exp_w = 32'd2; exp_a = 32'd1;
`else
    exp_r = 32'd0; exp_w = 32'd0; exp_a = 32'd0;
`endif
    chk("stat_reads",  stat_reads,  exp_r);
    chk("stat_writes", stat_writes, exp_w);
    chk("stat_aborts", stat_aborts, exp_a);

    // Illegal requests.
    r0 = ren_cnt; w0 = wen_cnt;
    go(); bus.memREN = 1'b1; bus.memWEN = 1'b1; bus.memaddr = 32'h40;
    smp(); chk("err_both", 32'(bus.ramstate), 32'(ERROR));
    chk("err_both_ren", 32'(sram_ren), 32'd0); chk("err_both_wen", 32'(sram_wen), 32'd0);
    go(); smp(); chk("err_both_hold", 32'(bus.ramstate), 32'(ERROR));
    go(); bus.memWEN = 1'b0; bus.memaddr = 32'h42;
    smp(); chk("err_misalign", 32'(bus.ramstate), 32'(ERROR));
    go(); bus.memaddr = 32'h0001_0000;
    smp(); chk("err_range", 32'(bus.ramstate), 32'(ERROR));
    go(); bus.memREN = 1'b0; bus.memaddr = 32'd0;
    smp(); chk("err_free", 32'(bus.ramstate), 32'(FREE));
    chk("err_no_strobe", 32'((ren_cnt - r0) + (wen_cnt - w0)), 32'd0);

    // Reset asserted in cycle 1 of a write to 0x4C.
    w0 = wen_cnt;
    go(); bus.memWEN = 1'b1; bus.memaddr = 32'h4C; bus.memstore = 32'hFFFF0000;
    smp(); chk("rw_c0_state", 32'(bus.ramstate), 32'(BUSY));
    go(); nRST = 1'b0;
    smp(); chk("rw_c1_wen", 32'(sram_wen), 32'd0);
    go(); bus.memWEN = 1'b0; nRST = 1'b1;
    smp(); chk("rw_free", 32'(bus.ramstate), 32'(FREE));
    go(); go(); smp();
    chk("rw_mem", mem[14'h13], 32'hA5A5A5A5);
    chk("rw_no_wen", 32'(wen_cnt - w0), 32'd0);
    chk("rw_load", bus.ramload, 32'd0);
    chk("rw_stat_r", stat_reads, 32'd0);
    chk("rw_stat_w", stat_writes, 32'd0);
    chk("rw_stat_a", stat_aborts, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
